conway_grid_serial_v5: RTL and testbench
========================================

// Module: conway_grid_serial_v5
// PURPOSE
//  Parametrised WxH Game of Life engine with a serial load/unload interface.
//  Successor to the fixed 8x8 serial top. Adds a generation counter, a run-N-generations limit,
//  still-life/extinction detection, non-destructive (rotating) readout and frame-boundary pulses.
//  Sits at chip top: pins -> this block -> cell_grid. LED mirroring stays in the pad wrapper.
// PARAMETERS
//  GRID_WIDTH   8   cells per row
//  GRID_HEIGHT  8   rows; N = GRID_WIDTH*GRID_HEIGHT state bits
//  GEN_W        16  width of generation counter and limit
// PORTS
//  CLK         in   1      system clock; all state on rising edge
//  RESET       in   1      asynchronous, active-high reset
//  DATA_IN     in   1      serial cell data, used in LOAD
//  MODE        in   2      00 LOAD, 01 RUN, 10 OUTPUT, 11 HOLD
//  GEN_LIMIT   in   GEN_W  generations to run; 0 = unlimited; latched on RUN entry
//  DATA_OUT    out  1      serial cell data, valid in OUTPUT
//  DATA_VALID  out  1      high while in OUTPUT mode
//  FRAME_DONE  out  1      1-cycle pulse on the last (Nth) bit of a LOAD or OUTPUT frame
//  GEN_COUNT   out  GEN_W  generations computed since RUN entry
//  STABLE      out  1      grid reached a still life; sticky until next RUN entry
//  EXTINCT     out  1      combinational: state memory == 0
//  DONE        out  1      RUN halted (limit reached or STABLE); sticky until next RUN entry
// BEHAVIOUR
//  Reset: mem=0, bit_cnt=0, mode_q=HOLD, GEN_COUNT=0, STABLE=0, DONE=0, FRAME_DONE=0.
//   DATA_OUT=0, DATA_VALID=0. EXTINCT=1 out of reset.
//  mode_q is MODE registered each cycle. "Entry" means MODE != mode_q. On entry, bit_cnt clears to 0.
//  LOAD: mem <= {mem[N-2:0], DATA_IN}; the first bit shifted in ends at mem[N-1].
//   Cell (r,c) is bit r*GRID_WIDTH+c (cell_grid mapping).
//  OUTPUT: DATA_OUT = mem[N-1] (combinational, gated by mode); mem <= {mem[N-2:0], mem[N-1]}.
//   After N cycles mem is restored. Partial frames leave mem rotated; no multiple-of-N requirement.
//  bit_cnt (LOAD/OUTPUT): increments per cycle. At N-1: FRAME_DONE=1 that cycle, then wraps to 0.
//  RUN entry cycle (setup): GEN_COUNT<=0, STABLE<=0, DONE<=0, limit_q<=GEN_LIMIT. mem unchanged.
//  RUN step (each later RUN cycle with DONE=0), next = cell_grid(mem):
//   - next==mem: STABLE<=1, DONE<=1; mem and GEN_COUNT unchanged.
//   - else: mem<=next, GEN_COUNT<=GEN_COUNT+1.
//     If limit_q!=0 and GEN_COUNT+1==limit_q, then DONE<=1.
//   - GEN_COUNT saturates at all-ones; saturation with limit_q==0 does not set DONE.
//   - Extinction is not a separate halt; an empty grid is a still life, so it halts via STABLE.
//  RUN with DONE=1: mem and counters frozen.
//  HOLD: mem, GEN_COUNT, STABLE, DONE all held; bit_cnt held.
//  Leaving RUN mid-run keeps GEN_COUNT/STABLE/DONE visible for readback. Re-entering RUN restarts them.
//  Latency: RUN entry to first new generation in mem = 2 edges. OUTPUT entry to first bit = 0 cycles.
//  RESET asserted mid-frame or mid-run: immediate clear to reset values; no partial completion.
// STRUCTURE
//  Package conway_pkg: mode_e enum {MODE_LOAD=2'b00, MODE_RUN, MODE_OUTPUT, MODE_HOLD}.
//   Also cell_index(r,c,W) function.
//  Sub-module system_memory_v5 #(N): N-bit register with LOAD shift / OUTPUT rotate / RUN parallel load,
//   plus bit_cnt and FRAME_DONE. Top holds mode_q, RUN control, counter and flags.
//  Existing cell_grid #(GRID_WIDTH,GRID_HEIGHT) provides next-state logic.
// TESTING
//  1 Reset, then OUTPUT 64 cycles
//    -> DATA_OUT=0 all bits; FRAME_DONE only on cycle 64; EXTINCT=1.
//  2 LOAD 2x2 block (cells (3,3),(3,4),(4,3),(4,4)), RUN 5 cycles, GEN_LIMIT=0
//    -> STABLE=1, DONE=1, GEN_COUNT=0.
//  3 LOAD horizontal blinker at row 3 cols 2-4, GEN_LIMIT=3, RUN
//    -> DONE after 4 cycles, GEN_COUNT=3, vertical phase in mem.
//  4 LOAD glider, OUTPUT 30 bits, HOLD, OUTPUT 34 bits
//    -> concatenated stream equals the loaded pattern; mem then equals the load.
//  5 Single live cell, RUN
//    -> after gen 1, EXTINCT=1; next cycle STABLE=1, DONE=1, GEN_COUNT=1.
//  6 Assert RESET mid-LOAD (bit 20) and mid-RUN
//    -> all outputs at reset values the same cycle; a new LOAD frame restarts FRAME_DONE count at 0.

Source files
------------

// File: rtl/conway_pkg.sv
// Shared types for the serial Game of Life engine: interface modes and
// the row-major cell numbering used by cell_grid and the serial stream.
package conway_pkg;

   typedef enum logic [1:0] {
      MODE_LOAD   = 2'b00,
      MODE_RUN    = 2'b01,
      MODE_OUTPUT = 2'b10,
      MODE_HOLD   = 2'b11
   } mode_e;

   function automatic int cell_index(input int r, input int c, input int w);
      return r * w + c;
   endfunction

endpackage

// File: rtl/cell_grid.sv
// Next-generation logic for a WxH Life grid; cells beyond the edge are dead.
module cell_grid
   import conway_pkg::*;
#(
   parameter int GRID_WIDTH  = 8,
   parameter int GRID_HEIGHT = 8
) (
   input  logic [GRID_WIDTH*GRID_HEIGHT-1:0] cells_i,
   output logic [GRID_WIDTH*GRID_HEIGHT-1:0] next_o
);

   for (genvar r = 0; r < GRID_HEIGHT; r++) begin : g_row
      for (genvar c = 0; c < GRID_WIDTH; c++) begin : g_col
         localparam int IDX = cell_index(r, c, GRID_WIDTH);
         logic [7:0] nb;
         logic [3:0] cnt;

         // k walks the 3x3 window; k==4 is the cell itself
         for (genvar k = 0; k < 9; k++) begin : g_nb
            if (k != 4) begin : g_use
               localparam int RR = r + k / 3 - 1;
               localparam int CC = c + k % 3 - 1;
               localparam int B  = (k < 4) ? k : k - 1;
               if (RR >= 0 && RR < GRID_HEIGHT && CC >= 0 && CC < GRID_WIDTH) begin : g_in
                  assign nb[B] = cells_i[cell_index(RR, CC, GRID_WIDTH)];
               end else begin : g_out
                  assign nb[B] = 1'b0;
               end
            end
         end

         assign cnt = 4'(nb[0]) + 4'(nb[1]) + 4'(nb[2]) + 4'(nb[3]) +
                      4'(nb[4]) + 4'(nb[5]) + 4'(nb[6]) + 4'(nb[7]);
         assign next_o[IDX] = (cnt == 4'd3) | (cells_i[IDX] & (cnt == 4'd2));
      end
   end

endmodule

// File: rtl/system_memory_v5.sv
// Grid state register: serial shift-in, rotating readout, parallel generation
// load, plus the frame bit counter that marks the last bit of a serial frame.
module system_memory_v5
   import conway_pkg::*;
#(
   parameter int N = 64
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  mode_e        mode_i,
   input  logic         entry_i,
   input  logic         data_in_i,
   input  logic         run_load_i,
   input  logic [N-1:0] next_i,
   output logic [N-1:0] mem_o,
   output logic         frame_done_o
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [N-1:0]  mem_q, mem_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
   logic          serial, last;

   // The entry cycle already counts as bit 0 of the new frame
   assign cnt_eff = entry_i ? '0 : cnt_q;
   assign serial  = (mode_i == MODE_LOAD) || (mode_i == MODE_OUTPUT);
   assign last    = (cnt_eff == LAST);

   always_comb begin
      mem_d = mem_q;
      cnt_d = cnt_eff;
      case (mode_i)
         MODE_LOAD:   mem_d = {mem_q[N-2:0], data_in_i};
         MODE_OUTPUT: mem_d = {mem_q[N-2:0], mem_q[N-1]};
         MODE_RUN:    if (run_load_i) mem_d = next_i;
         default:     mem_d = mem_q;
      endcase
      if (serial) cnt_d = last ? '0 : cnt_eff + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         cnt_q <= cnt_d;
      end
   end

   assign mem_o        = mem_q;
   assign frame_done_o = serial && last;

endmodule

// File: rtl/conway_grid_serial_v5.sv
// Parametrised Life engine top: mode tracking, RUN sequencing with generation
// counter / limit, still-life detection, and gated serial outputs.
module conway_grid_serial_v5
   import conway_pkg::*;
#(
   parameter int GRID_WIDTH  = 8,
   parameter int GRID_HEIGHT = 8,
   parameter int GEN_W       = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             DATA_IN,
   input  logic [1:0]       MODE,
   input  logic [GEN_W-1:0] GEN_LIMIT,
   output logic             DATA_OUT,
   output logic             DATA_VALID,
   output logic             FRAME_DONE,
   output logic [GEN_W-1:0] GEN_COUNT,
   output logic             STABLE,
   output logic             EXTINCT,
   output logic             DONE
);

   localparam int N = GRID_WIDTH * GRID_HEIGHT;

   mode_e            mode, mode_q;
   logic             entry, run_active, still, frame_done;
   logic [N-1:0]     mem, next_grid;
   logic [GEN_W-1:0] gen_q, gen_d, limit_q, limit_d;
   logic [GEN_W:0]   gen_sum;
   logic             stable_q, stable_d, done_q, done_d;

   assign mode       = mode_e'(MODE);
   assign entry      = (mode != mode_q);
   assign run_active = (mode == MODE_RUN) && !entry && !done_q;
   assign still      = (next_grid == mem);
   assign gen_sum    = {1'b0, gen_q} + 1'b1;

   cell_grid #(.GRID_WIDTH(GRID_WIDTH), .GRID_HEIGHT(GRID_HEIGHT)) u_grid (
      .cells_i (mem),
      .next_o  (next_grid)
   );

   system_memory_v5 #(.N(N)) u_mem (
      .clk_i        (CLK),
      .rst_i        (RESET),
      .mode_i       (mode),
      .entry_i      (entry),
      .data_in_i    (DATA_IN),
      .run_load_i   (run_active && !still),
      .next_i       (next_grid),
      .mem_o        (mem),
      .frame_done_o (frame_done)
   );

   always_comb begin
      gen_d    = gen_q;
      limit_d  = limit_q;
      stable_d = stable_q;
      done_d   = done_q;
      if (mode == MODE_RUN && entry) begin
         gen_d    = '0;
         limit_d  = GEN_LIMIT;
         stable_d = 1'b0;
         done_d   = 1'b0;
      end else if (run_active) begin
         if (still) begin
            stable_d = 1'b1;
            done_d   = 1'b1;
         end else begin
            // Saturate; the unsaturated sum still drives the limit compare
            if (!(&gen_q)) gen_d = gen_sum[GEN_W-1:0];
            if (limit_q != '0 && gen_sum == {1'b0, limit_q}) done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mode_q   <= MODE_HOLD;
         gen_q    <= '0;
         limit_q  <= '0;
         stable_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         mode_q   <= mode;
         gen_q    <= gen_d;
         limit_q  <= limit_d;
         stable_q <= stable_d;
         done_q   <= done_d;
      end
   end

   // Combinational outputs are forced quiet while reset is held
   assign DATA_VALID = !RESET && (mode == MODE_OUTPUT);
   assign DATA_OUT   = DATA_VALID && mem[N-1];
   assign FRAME_DONE = !RESET && frame_done;
   assign GEN_COUNT  = gen_q;
   assign STABLE     = stable_q;
   assign DONE       = done_q;
   assign EXTINCT    = (mem == '0);

endmodule

// File: tb/tb_conway_grid_serial_v5.sv
// Directed bench for the 8x8 serial Life engine: vector table of RUN scenarios
// plus hand sequences for readout, partial frames and mid-operation reset.
module tb_conway_grid_serial_v5;

   logic        CLK, RESET, DATA_IN;
   logic [1:0]  MODE;
   logic [15:0] GEN_LIMIT;
   logic        DATA_OUT, DATA_VALID, FRAME_DONE, STABLE, EXTINCT, DONE;
   logic [15:0] GEN_COUNT;

   int checks = 0;
   int errors = 0;

   conway_grid_serial_v5 dut (
      .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN), .MODE(MODE), .GEN_LIMIT(GEN_LIMIT),
      .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .FRAME_DONE(FRAME_DONE),
      .GEN_COUNT(GEN_COUNT), .STABLE(STABLE), .EXTINCT(EXTINCT), .DONE(DONE)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic [63:0] pat;
      logic [15:0] limit;
      int          cycles;
      logic [63:0] exp_mem;
      logic [15:0] exp_gen;
      logic        exp_stable;
      logic        exp_done;
      logic        exp_extinct;
   } vec_t;

   vec_t vecs[6];

   function automatic logic [63:0] cb(input int r, input int c);
      logic [63:0] v;
      v = '0;
      v[r*8+c] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic load_frame(input logic [63:0] pat, input int n, output logic [63:0] fd);
      fd = '0;
      for (int k = 0; k < n; k++) begin
         MODE = 2'b00;
         DATA_IN = pat[63-k];
         @(negedge CLK);
         fd[k] = FRAME_DONE;
         tick();
      end
   endtask

   task automatic read_bits(input int n, output logic [63:0] s, output logic [63:0] fd,
                            output logic allv);
      s = '0; fd = '0; allv = 1'b1;
      for (int k = 0; k < n; k++) begin
         MODE = 2'b10;
         @(negedge CLK);
         s = {s[62:0], DATA_OUT};
         fd[k] = FRAME_DONE;
         allv = allv & DATA_VALID;
         tick();
      end
   endtask

   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         MODE = 2'b01;
         tick();
      end
   endtask

   initial begin
      logic [63:0] fd, s, s1, blinker_h, blinker_v, glider, block;
      logic        allv;
      localparam logic [63:0] LASTBIT = 64'h8000_0000_0000_0000;

      block     = cb(3,3) | cb(3,4) | cb(4,3) | cb(4,4);
      blinker_h = cb(3,2) | cb(3,3) | cb(3,4);
      blinker_v = cb(2,3) | cb(3,3) | cb(4,3);
      glider    = cb(0,1) | cb(1,2) | cb(2,0) | cb(2,1) | cb(2,2);

      vecs[0] = '{block,     16'd0, 5,  block,                                         16'd0, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{blinker_h, 16'd3, 4,  blinker_v,                                     16'd3, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{cb(4,4),   16'd0, 3,  64'd0,                                         16'd1, 1'b1, 1'b1, 1'b1};
      vecs[3] = '{blinker_h, 16'd0, 6,  blinker_v,                                     16'd5, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{glider,    16'd4, 10, cb(1,2)|cb(2,3)|cb(3,1)|cb(3,2)|cb(3,3),       16'd4, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{blinker_h, 16'd3, 10, blinker_v,                                     16'd3, 1'b0, 1'b1, 1'b0};

      RESET = 1'b1; MODE = 2'b11; DATA_IN = 1'b0; GEN_LIMIT = '0;
      tick(); tick();
      @(negedge CLK);
      chk("rst_flags", {DATA_OUT, DATA_VALID, FRAME_DONE, STABLE, DONE, EXTINCT}, 6'b000001);
      chk("rst_gen", GEN_COUNT, 16'd0);
      tick();
      RESET = 1'b0;
      tick();

      // Empty grid readout: all zero, valid throughout, frame pulse on bit 64 only
      read_bits(64, s, fd, allv);
      chk("empty_stream", s, 64'd0);
      chk("empty_fd", fd, LASTBIT);
      chk("empty_valid", allv, 1'b1);
      MODE = 2'b11;
      @(negedge CLK);
      chk("empty_extinct", EXTINCT, 1'b1);
      chk("hold_valid", DATA_VALID, 1'b0);
      tick();

      for (int i = 0; i < 6; i++) begin
         GEN_LIMIT = vecs[i].limit;
         load_frame(vecs[i].pat, 64, fd);
         chk($sformatf("v%0d_load_fd", i), fd, LASTBIT);
         run_cycles(vecs[i].cycles);
         MODE = 2'b11;
         @(negedge CLK);
         chk($sformatf("v%0d_gen", i), GEN_COUNT, vecs[i].exp_gen);
         chk($sformatf("v%0d_flags", i), {STABLE, DONE, EXTINCT},
             {vecs[i].exp_stable, vecs[i].exp_done, vecs[i].exp_extinct});
         tick();
         read_bits(64, s, fd, allv);
         chk($sformatf("v%0d_mem", i), s, vecs[i].exp_mem);
      end

      // Split readout with a HOLD gap: stream still reassembles the pattern
      load_frame(glider, 64, fd);
      read_bits(30, s1, fd, allv);
      MODE = 2'b11; tick(); tick(); tick();
      read_bits(34, s, fd, allv);
      chk("split_stream", (s1 << 34) | s, glider);
      read_bits(64, s, fd, allv);
      chk("split_restored", s, glider);

      // Single cell: dies on gen 1, still life detected the cycle after
      GEN_LIMIT = 16'd0;
      load_frame(cb(4,4), 64, fd);
      run_cycles(2);
      @(negedge CLK);
      chk("single_g1", {EXTINCT, STABLE, DONE, 16'(GEN_COUNT)}, {3'b100, 16'd1});
      run_cycles(1);
      @(negedge CLK);
      chk("single_g2", {EXTINCT, STABLE, DONE, 16'(GEN_COUNT)}, {3'b111, 16'd1});

      // RUN entry cycle is setup only: gen 0 still in memory
      load_frame(blinker_h, 64, fd);
      run_cycles(1);
      MODE = 2'b11; tick();
      read_bits(64, s, fd, allv);
      chk("entry_setup_mem", s, blinker_h);

      // Reset in the middle of a LOAD frame
      load_frame(64'hFFFF_FFFF_FFFF_FFFF, 20, fd);
      RESET = 1'b1;
      #1;
      chk("rst_load_ext", {EXTINCT, FRAME_DONE, DATA_VALID}, 3'b100);
      tick();
      RESET = 1'b0;
      load_frame(glider, 64, fd);
      chk("rst_load_fd", fd, LASTBIT);
      read_bits(64, s, fd, allv);
      chk("rst_load_mem", s, glider);

      // Reset in the middle of a RUN, with OUTPUT requested during reset
      load_frame(blinker_h, 64, fd);
      run_cycles(3);
      @(negedge CLK);
      chk("pre_rst_gen", GEN_COUNT, 16'd2);
      tick();
      RESET = 1'b1; MODE = 2'b10;
      #1;
      chk("rst_run_flags", {DATA_OUT, DATA_VALID, FRAME_DONE, STABLE, DONE, EXTINCT}, 6'b000001);
      chk("rst_run_gen", GEN_COUNT, 16'd0);
      tick();
      MODE = 2'b11;
      RESET = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
